// File: rtl/serial_add.sv
// serial_add: LSB-first bit-serial adder built from two half-adder stages and a carry flip-flop.
module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_ar, r_br, r_sr, r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_cy, r_c, r_done;
    logic             w_p, w_g, w_bit, w_h, w_co, w_last;
    logic [WIDTH-1:0] w_sr_next;
    half_adder u_ha1 (.i_x(r_ar[0]), .i_y(r_br[0]), .o_s(w_p),   .o_c(w_g));
    half_adder u_ha2 (.i_x(w_p),     .i_y(r_cy),    .o_s(w_bit), .o_c(w_h));
    assign w_co      = w_g | w_h;
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_sr_next = (r_sr >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));
    assign busy      = r_state == SHIFT;
    assign done      = r_done;
    assign s         = r_s;
    assign c         = r_c;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ar    <= '0;
            r_br    <= '0;
            r_sr    <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_c     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_ar    <= a;
                    r_br    <= b;
                    r_cy    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
            end else begin
                r_cy  <= w_co;
                r_sr  <= w_sr_next;
                r_ar  <= r_ar >> 1;
                r_br  <= r_br >> 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_s     <= w_sr_next;
                    r_c     <= w_co;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: randomized and directed checks of serial_add against plain a+b arithmetic.
module tb_serial_add;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0, s;
    logic       busy, done, c;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, s1;
    logic       busy1, done1, c1;
    int         n_tests = 0;
    int         n_fail = 0;

    serial_add #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .c(c)
    );
    serial_add #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .s(s1), .c(c1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset w8: busy=%b done=%b s=%h c=%b want 0 0 00 0", busy, done, s, c);
        end
        n_tests++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || s1 !== 1'b0 || c1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset w1: busy=%b done=%b s=%b c=%b want 0 0 0 0", busy1, done1, s1, c1);
        end
        rst = 1'b0;
    endtask

    task automatic test_add(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] exp, prev;
        exp = {1'b0, x} + {1'b0, y};
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        prev = {c, s};
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0 || {c, s} !== prev) begin
                n_fail++;
                $display("FAIL add mid-op %h+%h cycle %0d: busy=%b done=%b cs=%h want busy=1 done=0 cs=%h",
                         x, y, i, busy, done, {c, s}, prev);
            end
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1 || {c, s} !== exp) begin
            n_fail++;
            $display("FAIL add done %h+%h: busy=%b done=%b cs=%h want busy=0 done=1 cs=%h",
                     x, y, busy, done, {c, s}, exp);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || {c, s} !== exp) begin
            n_fail++;
            $display("FAIL add after-done %h+%h: done=%b cs=%h want done=0 cs=%h", x, y, done, {c, s}, exp);
        end
    endtask

    task automatic test_directed;
        test_add(8'h5A, 8'h3C);
        test_add(8'hFF, 8'h01);
        test_add(8'hFF, 8'hFF);
        test_add(8'h00, 8'h00);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) test_add(8'($urandom), 8'($urandom));
    endtask

    task automatic test_start_ignored;
        int n_done = 0;
        int j_done = -1;
        logic [8:0] cs_done = '0;
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            start = (j == 3);
            a = 8'hAA;
            b = 8'h55;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                j_done = j;
                cs_done = {c, s};
            end
        end
        n_tests++;
        if (n_done != 1 || j_done != 8 || cs_done !== 9'h030) begin
            n_fail++;
            $display("FAIL start-while-busy: dones=%0d at edge k+%0d cs=%h want 1 at k+8 cs=030",
                     n_done, j_done, cs_done);
        end
    endtask

    task automatic test_reset_mid;
        int n_done = 0;
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (j == 4);
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid-op: busy=%b done=%b s=%h c=%b want 0 0 00 0", busy, done, s, c);
        end
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL reset mid-op done pulses: got %0d want 0", n_done);
        end
        test_add(8'h80, 8'h80);
    endtask

    task automatic test_back_to_back;
        int j1 = -1;
        int j2 = -1;
        logic [8:0] cs1 = '0, cs2 = '0;
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            start = (j <= 9);
            a = 8'h01;
            b = 8'h02;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (j1 < 0) begin
                    j1 = j;
                    cs1 = {c, s};
                end else if (j2 < 0) begin
                    j2 = j;
                    cs2 = {c, s};
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (j1 != 8 || cs1 !== 9'h077) begin
            n_fail++;
            $display("FAIL back-to-back first: done at k+%0d cs=%h want k+8 cs=077", j1, cs1);
        end
        n_tests++;
        if (j2 - j1 != 9 || cs2 !== 9'h003) begin
            n_fail++;
            $display("FAIL back-to-back second: gap=%0d cs=%h want gap=9 cs=003", j2 - j1, cs2);
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = 2'(i[1]) + 2'(i[0]);
            @(negedge clk);
            a1 = i[1];
            b1 = i[0];
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            n_tests++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1 shift %b+%b: busy=%b done=%b want 1 0", i[1], i[0], busy1, done1);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (busy1 !== 1'b0 || done1 !== 1'b1 || {c1, s1} !== exp) begin
                n_fail++;
                $display("FAIL w1 done %b+%b: busy=%b done=%b cs=%b want 0 1 %b",
                         i[1], i[0], busy1, done1, {c1, s1}, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_width1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Bit-serial adder that wraps the team's half-adder stage.
- Two half-adder instances plus one OR form a full-adder cell. A carry flip-flop feeds that cell, and the block adds two WIDTH-bit operands LSB-first, one bit per clock.
- Sits upstream of result consumers. Used where area matters more than latency.
- Start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when s and c become valid
- s  output  WIDTH  registered sum; holds until the next completion
- c  output  1  registered carry-out; holds until the next completion

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Everything updates only on the rising edge of clk.
- Reset (rst high at an edge):
  - state returns to IDLE.
  - busy=0, done=0, s=0, c=0.
  - Operand shift registers, sum shift register, carry flip-flop and bit counter all clear.
  - rst has priority over start and over any operation in progress.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- IDLE:
  - start=1 at an edge:
    - a and b load into shift registers ar and br.
    - Carry flip-flop cy clears to 0 and counter cnt clears to 0.
    - Next state is SHIFT.
  - start=0: state, s and c hold.
- SHIFT, at each edge:
  - Half-adder 1: p = ar[0]^br[0], g = ar[0]&br[0].
  - Half-adder 2: bit = p^cy, h = p&cy.
  - cy <= g|h.
  - bit shifts into the MSB of sum register sr. sr, ar and br each shift right by one.
  - cnt increments.
- Completion, on the edge where cnt==WIDTH-1:
  - s <= final sr value, including this edge's bit.
  - c <= g|h.
  - done <= 1.
  - Next state is IDLE.
- done is high for exactly one cycle after completion and is 0 in every other cycle.
- Latency:
  - start accepted at edge k → busy high during cycles k+1..k+WIDTH.
  - done high during the cycle following edge k+WIDTH.
  - s and c are valid from that cycle onward.
  - Throughput: one addition per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-captured and the operation in progress is unaffected.
- start during the done cycle is accepted: the state is already IDLE. Back-to-back operations run with no gap.
- a and b may change freely after the capture edge.
- s and c never change mid-operation; they update only on completion.
- Reset mid-operation aborts the addition: no done pulse, and s and c clear to 0.
- Arithmetic is unsigned, modulo 2^WIDTH, with the carry in c: {c,s} = a+b exactly.
- WIDTH=1: a single SHIFT cycle; done follows one cycle after the start edge's successor.
- cnt is sized for values 0..WIDTH-1, with a minimum width of 1 bit.

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x3C, start pulsed 1 cycle at edge k → busy high for cycles k+1..k+8; done one-cycle pulse after edge k+8; s=0x96, c=0.
- a=0xFF, b=0x01 → s=0x00, c=1. Then a=0xFF, b=0xFF → s=0xFE, c=1. Then a=0x00, b=0x00 → s=0x00, c=0.
- Start with a=0x10, b=0x20. At cycle k+3, raise start with a=0xAA, b=0x55 → still exactly one done after edge k+8; s=0x30, c=0; second request dropped.
- Start with a=0x80, b=0x80. Assert rst at edge k+4 → no done pulse; busy=0, s=0x00, c=0 after that edge. A new start then completes normally.
- Back-to-back: start held high through the done cycle with new operands 0x01+0x02 → second done exactly 9 cycles after the first; s=0x03.
- WIDTH=1 build: a=1, b=1 → s=0, c=1 with done one cycle after the SHIFT edge. Sweep all 4 input pairs.
